// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared state encoding and sizing helpers for the matrix multiplier
package matrix_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Result width that can hold a full N-term dot product without overflow.
   function automatic int calc_ow(input int dw, input int n);
      return 2 * dw + $clog2(n);
   endfunction

   function automatic int elem_idx(input int r, input int c, input int n);
      return r * n + c;
   endfunction

endpackage

// File: rtl/matrix_mult_seq_if.sv
// rtl/matrix_mult_seq_if.sv - start/done control and flattened operand/result buses
interface matrix_mult_seq_if #(
   parameter int N  = 2,
   parameter int DW = 4,
   parameter int OW = matrix_pkg::calc_ow(DW, N)
);
   logic                start;
   logic [N*N*DW-1:0]   a_flat;
   logic [N*N*DW-1:0]   b_flat;
   logic [N*N*OW-1:0]   c_flat;
   logic                busy;
   logic                done;

   modport master (output start, a_flat, b_flat, input  c_flat, busy, done);
   modport slave  (input  start, a_flat, b_flat, output c_flat, busy, done);
endinterface

// File: rtl/matrix_mac_unit.sv
// rtl/matrix_mac_unit.sv - combinational multiply-add of one operand pair into the accumulator
module matrix_mac_unit #(
   parameter int DW     = 4,
   parameter int OW     = 9,
   parameter int SIGNED = 0
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [OW-1:0] acc_in,
   output logic [OW-1:0] acc_out
);
   logic [OW-1:0] a_ext;
   logic [OW-1:0] b_ext;
   logic [OW-1:0] prod;

   generate
      if (SIGNED != 0) begin : g_signed
         assign a_ext = {{(OW-DW){a[DW-1]}}, a};
         assign b_ext = {{(OW-DW){b[DW-1]}}, b};
      end else begin : g_unsigned
         assign a_ext = {{(OW-DW){1'b0}}, a};
         assign b_ext = {{(OW-DW){1'b0}}, b};
      end
   endgenerate

   // The low OW bits of the product are the same for signed and unsigned once extended.
   assign prod    = a_ext * b_ext;
   assign acc_out = acc_in + prod;
endmodule

// File: rtl/matrix_mult_seq.sv
// rtl/matrix_mult_seq.sv - sequential NxN matrix multiplier, one MAC per clock
module matrix_mult_seq
   import matrix_pkg::*;
#(
   parameter int N      = 2,
   parameter int DW     = 4,
   parameter int SIGNED = 0,
   localparam int OW    = calc_ow(DW, N)
) (
   input  logic             clk,
   input  logic             rst_n,
   matrix_mult_seq_if.slave bus
);
   localparam int IW = $clog2(N);
   localparam int EW = $clog2(N*N);
   localparam int NE = N*N;
   localparam logic [IW-1:0] LAST = IW'(N-1);

   logic [1:0]          state_q, state_d;
   logic [DW-1:0]       a_q  [NE];
   logic [DW-1:0]       a_d  [NE];
   logic [DW-1:0]       b_q  [NE];
   logic [DW-1:0]       b_d  [NE];
   logic [OW-1:0]       cw_q [NE];
   logic [OW-1:0]       cw_d [NE];
   logic [NE*OW-1:0]    c_q, c_d;
   logic [IW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
   logic [OW-1:0]       acc_q, acc_d, acc_next;
   logic                busy_q, busy_d, done_q, done_d;
   logic [EW-1:0]       ik_idx, kj_idx, ij_idx;

   assign ik_idx = EW'(elem_idx(int'(i_q), int'(k_q), N));
   assign kj_idx = EW'(elem_idx(int'(k_q), int'(j_q), N));
   assign ij_idx = EW'(elem_idx(int'(i_q), int'(j_q), N));

   matrix_mac_unit #(.DW(DW), .OW(OW), .SIGNED(SIGNED)) u_mac (
      .a       (a_q[ik_idx]),
      .b       (b_q[kj_idx]),
      .acc_in  (acc_q),
      .acc_out (acc_next)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cw_d    = cw_q;
      c_d     = c_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      acc_d   = acc_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               for (int e = 0; e < NE; e++) begin
                  a_d[e] = bus.a_flat[e*DW +: DW];
                  b_d[e] = bus.b_flat[e*DW +: DW];
               end
               acc_d   = '0;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               busy_d  = 1'b1;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (k_q == LAST) begin
               cw_d[ij_idx] = acc_next;
               acc_d        = '0;
               k_d          = '0;
               if (j_q == LAST) begin
                  j_d = '0;
                  if (i_q == LAST) begin
                     // Publish the whole result at once so c_flat never shows a mix of runs.
                     for (int e = 0; e < NE; e++) begin
                        c_d[e*OW +: OW] = cw_d[e];
                     end
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     i_d = i_q + 1'b1;
                  end
               end else begin
                  j_d = j_q + 1'b1;
               end
            end else begin
               acc_d = acc_next;
               k_d   = k_q + 1'b1;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '{default: '0};
         b_q     <= '{default: '0};
         cw_q    <= '{default: '0};
         c_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cw_q    <= cw_d;
         c_q     <= c_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.c_flat = c_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_matrix_mult_seq.sv
// tb/tb_matrix_mult_seq.sv - scoreboard bench for three matrix multiplier configurations
module tb_matrix_mult_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   matrix_mult_seq_if #(.N(2), .DW(4)) bus2  ();
   matrix_mult_seq_if #(.N(2), .DW(4)) bus2s ();
   matrix_mult_seq_if #(.N(3), .DW(8)) bus3  ();

   matrix_mult_seq #(.N(2), .DW(4), .SIGNED(0)) u_dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
   matrix_mult_seq #(.N(2), .DW(4), .SIGNED(1)) u_dut2s (.clk(clk), .rst_n(rst_n), .bus(bus2s));
   matrix_mult_seq #(.N(3), .DW(8), .SIGNED(0)) u_dut3  (.clk(clk), .rst_n(rst_n), .bus(bus3));

   logic [255:0] sb2[$];
   logic [255:0] sb2s[$];
   logic [255:0] sb3[$];
   logic [255:0] last_exp [3];

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] mm_ref(input logic [255:0] a, input logic [255:0] b,
                                           input int n, input int dw, input int sgn);
      int ow;
      logic [255:0] c, t;
      longint acc, x, y;
      ow = 2 * dw + $clog2(n);
      c  = '0;
      for (int r = 0; r < n; r++) begin
         for (int cc = 0; cc < n; cc++) begin
            acc = 0;
            for (int k = 0; k < n; k++) begin
               x = longint'((a >> ((r*n+k)*dw))  & ((256'd1 << dw) - 256'd1));
               y = longint'((b >> ((k*n+cc)*dw)) & ((256'd1 << dw) - 256'd1));
               if (sgn != 0 && x >= (longint'(1) << (dw-1))) x -= longint'(1) << dw;
               if (sgn != 0 && y >= (longint'(1) << (dw-1))) y -= longint'(1) << dw;
               acc += x * y;
            end
            t = 256'(acc) & ((256'd1 << ow) - 256'd1);
            c = c | (t << ((r*n+cc)*ow));
         end
      end
      return c;
   endfunction

   function automatic logic [255:0] rand_vec();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic drive(input int sel, input logic st, input logic [255:0] a, input logic [255:0] b);
      case (sel)
         0: begin bus2.start  = st; bus2.a_flat  = a[15:0]; bus2.b_flat  = b[15:0]; end
         1: begin bus2s.start = st; bus2s.a_flat = a[15:0]; bus2s.b_flat = b[15:0]; end
         default: begin bus3.start = st; bus3.a_flat = a[71:0]; bus3.b_flat = b[71:0]; end
      endcase
   endtask

   task automatic set_start(input int sel, input logic st);
      case (sel)
         0: bus2.start = st;
         1: bus2s.start = st;
         default: bus3.start = st;
      endcase
   endtask

   task automatic sample(input int sel, output logic bz, output logic dn, output logic [255:0] c);
      case (sel)
         0: begin bz = bus2.busy;  dn = bus2.done;  c = 256'(bus2.c_flat);  end
         1: begin bz = bus2s.busy; dn = bus2s.done; c = 256'(bus2s.c_flat); end
         default: begin bz = bus3.busy; dn = bus3.done; c = 256'(bus3.c_flat); end
      endcase
   endtask

   task automatic push_exp(input int sel, input logic [255:0] e);
      case (sel)
         0: sb2.push_back(e);
         1: sb2s.push_back(e);
         default: sb3.push_back(e);
      endcase
   endtask

   function automatic logic [255:0] ref_for(input int sel, input logic [255:0] a, input logic [255:0] b);
      return mm_ref(a, b, (sel == 2) ? 3 : 2, (sel == 2) ? 8 : 4, (sel == 1) ? 1 : 0);
   endfunction

   // One start pulse; returns done latency (cycles after the accepting edge) and busy cycle count.
   task automatic run(input int sel, input logic [255:0] a, input logic [255:0] b,
                      input bit hold_chk, input bit repulse, output int lat, output int bcnt);
      int n3;
      logic bz, dn;
      logic [255:0] c, e;
      n3 = (sel == 2) ? 27 : 8;
      e  = ref_for(sel, a, b);
      @(negedge clk);
      drive(sel, 1'b1, a, b);
      push_exp(sel, e);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, rand_vec(), rand_vec());
      lat  = 0;
      bcnt = 0;
      for (int cyc = 1; cyc <= 200 && lat == 0; cyc++) begin
         @(negedge clk);
         sample(sel, bz, dn, c);
         if (bz) bcnt++;
         if (hold_chk && cyc == n3) check_eq("hold_prev", c, last_exp[sel]);
         if (repulse && cyc == 5) set_start(sel, 1'b1);
         if (repulse && cyc == 6) set_start(sel, 1'b0);
         if (dn) lat = cyc;
      end
      last_exp[sel] = e;
      @(negedge clk);
      sample(sel, bz, dn, c);
      check_eq("busy_fall", 256'(bz), 256'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus2.done) begin
         check_eq("done2_pending", 256'(sb2.size() != 0), 256'd1);
         if (sb2.size() != 0) check_eq("c2", 256'(bus2.c_flat), sb2.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus2s.done) begin
         check_eq("done2s_pending", 256'(sb2s.size() != 0), 256'd1);
         if (sb2s.size() != 0) check_eq("c2s", 256'(bus2s.c_flat), sb2s.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus3.done) begin
         check_eq("done3_pending", 256'(sb3.size() != 0), 256'd1);
         if (sb3.size() != 0) check_eq("c3", 256'(bus3.c_flat), sb3.pop_front());
      end
   end

   initial begin
      int lat, bcnt, d1, d2, acc2;
      logic bz, dn, prev_bz;
      logic [255:0] c, a1, b1, a2, b2, e1, e2;

      last_exp = '{default: '0};
      rst_n = 1'b0;
      drive(0, 1'b0, '0, '0);
      drive(1, 1'b0, '0, '0);
      drive(2, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      check_eq("rst_c2",    256'(bus2.c_flat), 256'd0);
      check_eq("rst_busy2", 256'(bus2.busy),   256'd0);
      check_eq("rst_done2", 256'(bus2.done),   256'd0);
      check_eq("rst_c3",    256'(bus3.c_flat), 256'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_busy3", 256'(bus3.busy), 256'd0);

      // 2x2 unsigned: A=[1 2;3 4], B=[5 6;7 8]
      run(0, 256'h4321, 256'h8765, 1'b1, 1'b0, lat, bcnt);
      check_eq("lat_n2", 256'(lat), 256'd9);
      check_eq("busy_n2", 256'(bcnt), 256'd9);
      check_eq("c2_00", 256'(bus2.c_flat[8:0]),   256'd19);
      check_eq("c2_01", 256'(bus2.c_flat[17:9]),  256'd22);
      check_eq("c2_10", 256'(bus2.c_flat[26:18]), 256'd43);
      check_eq("c2_11", 256'(bus2.c_flat[35:27]), 256'd50);

      run(0, 256'hFFFF, 256'hFFFF, 1'b1, 1'b0, lat, bcnt);
      check_eq("c2_max", 256'(bus2.c_flat[35:27]), 256'd450);

      // 2x2 signed: A=[-1 2;3 -4], B=[5 6;7 -8]
      run(1, 256'hC32F, 256'h8765, 1'b0, 1'b0, lat, bcnt);
      check_eq("lat_n2s", 256'(lat), 256'd9);
      check_eq("c2s_00", 256'(bus2s.c_flat[8:0]),   256'd9);
      check_eq("c2s_01", 256'(bus2s.c_flat[17:9]),  256'h1EA);
      check_eq("c2s_10", 256'(bus2s.c_flat[26:18]), 256'h1F3);
      check_eq("c2s_11", 256'(bus2s.c_flat[35:27]), 256'd50);

      for (int t = 0; t < 4; t++) begin
         run(t % 2, rand_vec(), rand_vec(), 1'b1, 1'b0, lat, bcnt);
         check_eq("lat_rand2", 256'(lat), 256'd9);
      end

      // 3x3: random run first so the identity run can check that the old result is held
      run(2, rand_vec(), rand_vec(), 1'b1, 1'b0, lat, bcnt);
      run(2, 256'h01_00000001_00000001, 256'h09_08_07_06_05_04_03_02_01, 1'b1, 1'b0, lat, bcnt);
      check_eq("lat_n3", 256'(lat), 256'd28);
      check_eq("busy_n3", 256'(bcnt), 256'd28);
      check_eq("c3_12", 256'(bus3.c_flat[5*18 +: 18]), 256'd6);
      check_eq("c3_22", 256'(bus3.c_flat[8*18 +: 18]), 256'd9);

      run(2, rand_vec(), rand_vec(), 1'b1, 1'b1, lat, bcnt);
      check_eq("lat_repulse", 256'(lat), 256'd28);
      repeat (40) @(negedge clk);
      check_eq("repulse_single", 256'(sb3.size()), 256'd0);

      // start held high across two runs
      a1 = rand_vec(); b1 = rand_vec(); a2 = rand_vec(); b2 = rand_vec();
      e1 = ref_for(2, a1, b1);
      e2 = ref_for(2, a2, b2);
      @(negedge clk);
      drive(2, 1'b1, a1, b1);
      sb3.push_back(e1);
      @(posedge clk);
      #1;
      drive(2, 1'b1, a2, b2);
      sb3.push_back(e2);
      d1 = 0; d2 = 0; acc2 = 0; prev_bz = 1'b1;
      for (int cyc = 1; cyc <= 150 && d2 == 0; cyc++) begin
         @(negedge clk);
         sample(2, bz, dn, c);
         if (d1 != 0 && acc2 == 0 && bz && !prev_bz) acc2 = cyc;
         if (dn && d1 == 0) d1 = cyc;
         else if (dn && acc2 != 0) begin
            d2 = cyc;
            set_start(2, 1'b0);
         end
         prev_bz = bz;
      end
      check_eq("held_lat1", 256'(d1), 256'd28);
      check_eq("held_lat2", 256'(d2 - acc2 + 1), 256'd28);
      last_exp[2] = e2;
      repeat (40) @(negedge clk);
      check_eq("held_two_runs", 256'(sb3.size()), 256'd0);

      // asynchronous reset in the middle of CALC
      @(negedge clk);
      drive(2, 1'b1, rand_vec(), rand_vec());
      @(posedge clk);
      #1;
      drive(2, 1'b0, rand_vec(), rand_vec());
      repeat (10) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_busy", 256'(bus3.busy),   256'd0);
      check_eq("arst_done", 256'(bus3.done),   256'd0);
      check_eq("arst_c",    256'(bus3.c_flat), 256'd0);
      last_exp[2] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      run(2, rand_vec(), rand_vec(), 1'b1, 1'b0, lat, bcnt);
      check_eq("lat_after_rst", 256'(lat), 256'd28);

      repeat (5) @(negedge clk);
      check_eq("sb_empty", 256'(sb2.size() + sb2s.size() + sb3.size()), 256'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
